alu_issue_stage: RTL and testbench



---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_op_decode.sv | 51 +++++
 rtl/alu_issue_stage.sv | 129 ++++++++++++
 tb/tb_alu_issue_stage.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue stage: control codes, funct3 values, skid states.
package alu_pkg;

    localparam int unsigned XLEN_DEFAULT   = 32;
    localparam int unsigned CTRL_W_DEFAULT = 4;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_XOR  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SLT  = 4'd7;
    localparam logic [3:0] ALU_SLTU = 4'd8;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational RV32I arithmetic decode: funct3/funct7b5/is_imm -> ALU control,
// operand_b selection and illegal-op flag.
module alu_op_decode
    import alu_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEFAULT,
    parameter int unsigned CTRL_W = CTRL_W_DEFAULT
) (
    input  logic [2:0]        funct3,
    input  logic              funct7b5,
    input  logic              is_imm,
    input  logic [XLEN-1:0]   rs2_data,
    input  logic [XLEN-1:0]   imm,
    output logic [CTRL_W-1:0] control_c,
    output logic [XLEN-1:0]   operand_b_c,
    output logic              illegal_c
);

    logic       is_shift;
    logic [3:0] code;

    always_comb begin
        is_shift    = (funct3 == F3_SLL) || (funct3 == F3_SR);
        operand_b_c = is_imm ? imm : rs2_data;
        if (is_imm && is_shift) begin
            operand_b_c = XLEN'(imm[4:0]);
        end

        // No arithmetic shift in this ALU; shamt upper bits must be clear
        illegal_c = ((funct3 == F3_SR) && funct7b5)
                 || (is_imm && is_shift && (imm[11:5] != 7'd0))
                 || (!is_imm && funct7b5 && (funct3 != F3_ADD) && (funct3 != F3_SR));

        code = ALU_ADD;
        case (funct3)
            F3_ADD:  code = (!is_imm && funct7b5) ? ALU_SUB : ALU_ADD;
            F3_SLL:  code = ALU_SLL;
            F3_SLT:  code = ALU_SLT;
            F3_SLTU: code = ALU_SLTU;
            F3_XOR:  code = ALU_XOR;
            F3_SR:   code = ALU_SRL;
            F3_OR:   code = ALU_OR;
            F3_AND:  code = ALU_AND;
        endcase
        if (illegal_c) begin
            code = ALU_ADD;
        end
        control_c = CTRL_W'(code);
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Execute-stage front end: decodes the op and holds ALU inputs in a 2-entry
// skid buffer so the ALU only ever sees registered operands.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEFAULT,
    parameter int unsigned CTRL_W = CTRL_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_funct3,
    input  logic              in_funct7b5,
    input  logic              in_is_imm,
    input  logic [XLEN-1:0]   in_rs1_data,
    input  logic [XLEN-1:0]   in_rs2_data,
    input  logic [XLEN-1:0]   in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   operand_a,
    output logic [XLEN-1:0]   operand_b,
    output logic [CTRL_W-1:0] control,
    output logic              out_illegal
);

    localparam int unsigned PAY_W = 2 * XLEN + CTRL_W + 1;

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic              accept_c;
    logic              consume_c;
    logic              load_main_c;
    logic              load_skid_c;
    logic              skid_to_main_c;
    logic [CTRL_W-1:0] dec_control_c;
    logic [XLEN-1:0]   dec_operand_b_c;
    logic              dec_illegal_c;
    logic [PAY_W-1:0]  in_pay_c;
    logic [PAY_W-1:0]  main_q;
    logic [PAY_W-1:0]  skid_q;

    alu_op_decode #(
        .XLEN   (XLEN),
        .CTRL_W (CTRL_W)
    ) u_decode (
        .funct3      (in_funct3),
        .funct7b5    (in_funct7b5),
        .is_imm      (in_is_imm),
        .rs2_data    (in_rs2_data),
        .imm         (in_imm),
        .control_c   (dec_control_c),
        .operand_b_c (dec_operand_b_c),
        .illegal_c   (dec_illegal_c)
    );

    assign in_pay_c = {in_rs1_data, dec_operand_b_c, dec_control_c, dec_illegal_c};
    assign {operand_a, operand_b, control, out_illegal} = main_q;

    // Skid FSM next state; flush overrides any accept/consume in the same cycle
    always_comb begin
        state_d        = state_q;
        load_main_c    = 1'b0;
        load_skid_c    = 1'b0;
        skid_to_main_c = 1'b0;
        accept_c       = in_valid && in_ready;
        consume_c      = out_valid && out_ready;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept_c) begin
                        state_d     = ST_ONE;
                        load_main_c = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept_c && consume_c) begin
                        load_main_c = 1'b1;
                    end else if (accept_c) begin
                        state_d     = ST_FULL;
                        load_skid_c = 1'b1;
                    end else if (consume_c) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (consume_c) begin
                        state_d        = ST_ONE;
                        skid_to_main_c = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // State plus registered handshake decodes (no out_ready -> in_ready path)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            state_q   <= state_d;
            out_valid <= (state_d != ST_EMPTY);
            in_ready  <= (state_d != ST_FULL);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_c) begin
                main_q <= in_pay_c;
            end else if (skid_to_main_c) begin
                main_q <= skid_q;
            end
            if (load_skid_c) begin
                skid_q <= in_pay_c;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: a queue-based buffer model checked every
// cycle, plus hand-computed expectations at key points.
module tb_alu_issue_stage;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctrl;
        logic        ill;
    } op_t;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_funct3;
    logic        in_funct7b5;
    logic        in_is_imm;
    logic [31:0] in_rs1_data;
    logic [31:0] in_rs2_data;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [3:0]  control;
    logic        out_illegal;

    int  checks = 0;
    int  errors = 0;
    int  dut_cons = 0;
    bit  cmp_en = 0;
    bit  stream_drop = 0;
    op_t exp_q[$];

    // ALU code per funct3 (legal, non-sub case)
    logic [3:0] f3_ctrl [8] = '{4'd0, 4'd5, 4'd7, 4'd8, 4'd3, 4'd6, 4'd4, 4'd2};

    alu_issue_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_funct3   (in_funct3),
        .in_funct7b5 (in_funct7b5),
        .in_is_imm   (in_is_imm),
        .in_rs1_data (in_rs1_data),
        .in_rs2_data (in_rs2_data),
        .in_imm      (in_imm),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .control     (control),
        .out_illegal (out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic op_t exp_decode(input logic [2:0] f3, input logic f7, input logic im,
                                       input logic [31:0] r1, input logic [31:0] r2,
                                       input logic [31:0] iv);
        op_t o;
        logic shift;
        shift = (f3 == 3'd1) || (f3 == 3'd5);
        o.a   = r1;
        o.b   = !im ? r2 : (shift ? {27'd0, iv[4:0]} : iv);
        o.ill = (f3 == 3'd5 && f7) || (im && shift && iv[11:5] != 7'd0)
             || (!im && f7 && f3 != 3'd0 && f3 != 3'd5);
        o.ctrl = f3_ctrl[f3];
        if (f3 == 3'd0 && !im && f7) o.ctrl = 4'd1;
        if (o.ill) o.ctrl = 4'd0;
        return o;
    endfunction

    // Model: the stage is a FIFO of depth 2 with one-cycle input-to-output latency
    always @(posedge clk or negedge rst_n) begin
        bit cons;
        bit acc;
        if (!rst_n || flush) begin
            exp_q.delete();
        end else begin
            cons = (exp_q.size() > 0) && out_ready;
            acc  = in_valid && (exp_q.size() < 2);
            if (cons) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(exp_decode(in_funct3, in_funct7b5, in_is_imm,
                                                in_rs1_data, in_rs2_data, in_imm));
        end
    end

    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready) dut_cons++;
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            chk("cyc_in_ready", 32'(in_ready), 32'(exp_q.size() < 2));
            chk("cyc_out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
            if (exp_q.size() > 0) begin
                chk("cyc_operand_a", operand_a, exp_q[0].a);
                chk("cyc_operand_b", operand_b, exp_q[0].b);
                chk("cyc_control", 32'(control), 32'(exp_q[0].ctrl));
                chk("cyc_illegal", 32'(out_illegal), 32'(exp_q[0].ill));
            end
        end
    end

    task automatic drive(input logic [2:0] f3, input logic f7, input logic im,
                         input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] iv);
        in_valid    = 1'b1;
        in_funct3   = f3;
        in_funct7b5 = f7;
        in_is_imm   = im;
        in_rs1_data = r1;
        in_rs2_data = r2;
        in_imm      = iv;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_valid = 1'b0; in_funct3 = 3'd0; in_funct7b5 = 1'b0; in_is_imm = 1'b0;
        in_rs1_data = '0; in_rs2_data = '0; in_imm = '0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_control", 32'(control), 32'd0);
        chk("rst_operand_a", operand_a, 32'd0);
        chk("rst_operand_b", operand_b, 32'd0);
        chk("rst_illegal", 32'(out_illegal), 32'd0);
        #2 rst_n = 1'b1;
        cmp_en = 1'b1;
        @(negedge clk);

        // R-type sub 16 - 8
        drive(3'd0, 1'b1, 1'b0, 32'd16, 32'd8, 32'd0);
        @(negedge clk);
        chk("sub_valid", 32'(out_valid), 32'd1);
        chk("sub_control", 32'(control), 32'd1);
        chk("sub_a", operand_a, 32'd16);
        chk("sub_b", operand_b, 32'd8);
        chk("sub_result", operand_a - operand_b, 32'd8);
        idle();
        @(negedge clk);

        // slli legal then with shamt upper bits set
        drive(3'd1, 1'b0, 1'b1, 32'hFFFF_FFF0, 32'd0, 32'h0000_000C);
        @(negedge clk);
        chk("slli_control", 32'(control), 32'd5);
        chk("slli_b", operand_b, 32'd12);
        chk("slli_illegal", 32'(out_illegal), 32'd0);
        drive(3'd1, 1'b1, 1'b1, 32'hFFFF_FFF0, 32'd0, 32'h0000_040C);
        @(negedge clk);
        chk("slli_bad_illegal", 32'(out_illegal), 32'd1);
        chk("slli_bad_control", 32'(control), 32'd0);
        chk("slli_bad_b", operand_b, 32'd12);
        idle();
        @(negedge clk);

        // Backpressure: sltu, slt, xor with out_ready low
        out_ready = 1'b0;
        drive(3'd3, 1'b0, 1'b0, 32'd1, 32'd2, 32'd0);
        @(negedge clk);
        chk("bp_ready_1", 32'(in_ready), 32'd1);
        drive(3'd2, 1'b0, 1'b0, 32'd3, 32'd4, 32'd0);
        @(negedge clk);
        chk("bp_ready_2", 32'(in_ready), 32'd0);
        drive(3'd4, 1'b0, 1'b0, 32'd5, 32'd6, 32'd0);
        @(negedge clk);
        chk("bp_hold_ready", 32'(in_ready), 32'd0);
        chk("bp_hold_ctrl", 32'(control), 32'd8);
        out_ready = 1'b1;
        chk("bp_out_0", 32'(control), 32'd8);
        @(negedge clk);
        chk("bp_out_1", 32'(control), 32'd7);
        chk("bp_ready_back", 32'(in_ready), 32'd1);
        @(negedge clk);
        chk("bp_out_2", 32'(control), 32'd3);
        idle();
        @(negedge clk);
        chk("bp_drained", 32'(out_valid), 32'd0);

        // Streaming 20 ops
        dut_cons = 0;
        for (int i = 0; i < 20; i++) begin
            if (!in_ready) stream_drop = 1'b1;
            drive(3'(i), (i % 3) == 0, 1'(i), 32'(i * 7 + 1), 32'(i * 13 + 2), 32'(i * 5));
            @(negedge clk);
        end
        idle();
        repeat (2) @(negedge clk);
        chk("stream_count", 32'(dut_cons), 32'd20);
        chk("stream_no_drop", 32'(stream_drop), 32'd0);

        // Flush while FULL with a pending input
        out_ready = 1'b0;
        drive(3'd6, 1'b0, 1'b0, 32'd10, 32'd11, 32'd0);
        @(negedge clk);
        drive(3'd7, 1'b0, 1'b0, 32'd12, 32'd13, 32'd0);
        @(negedge clk);
        drive(3'd0, 1'b0, 1'b0, 32'hDEAD, 32'd1, 32'd0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        idle();
        chk("fl_full_valid", 32'(out_valid), 32'd0);
        chk("fl_full_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("fl_full_gone", 32'(out_valid), 32'd0);
        end

        // Flush in ONE: input offered with in_ready high is discarded
        out_ready = 1'b0;
        drive(3'd4, 1'b0, 1'b1, 32'd20, 32'd0, 32'd7);
        @(negedge clk);
        drive(3'd6, 1'b0, 1'b1, 32'd21, 32'd0, 32'd9);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        idle();
        chk("fl_one_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("fl_one_gone", 32'(out_valid), 32'd0);

        // Asynchronous reset mid-stream while FULL
        drive(3'd3, 1'b0, 1'b0, 32'd30, 32'd31, 32'd0);
        @(negedge clk);
        drive(3'd2, 1'b0, 1'b0, 32'd32, 32'd33, 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_out_valid", 32'(out_valid), 32'd0);
        chk("mr_in_ready", 32'(in_ready), 32'd1);
        chk("mr_control", 32'(control), 32'd0);
        chk("mr_operand_a", operand_a, 32'd0);
        idle();
        @(negedge clk);
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("mr_after", 32'(out_valid), 32'd0);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
